// File: rtl/cmd_decode_queue_pkg.sv
// cmd_decode_pkg: shared definitions for the command decode queue.
//   - Bit positions of the fields packed into a host command word.
//   - Default field widths and the LOAD / STORE opcode defaults.
//   - cmd_t: one decoded command as stored in the queue.
// Optional build macro used by the block: CMD_PARITY_EN.
package cmd_decode_pkg;

    localparam int CMD_REG_W    = 5;
    localparam int CMD_IMM_W    = 16;
    localparam int CMD_OP_W     = 4;
    localparam int CMD_LOAD_OP  = 12;
    localparam int CMD_STORE_OP = 13;

    // Field map inside write_data (rs2 and imm overlap on purpose).
    localparam int RD_LSB  = 21;
    localparam int RD_MSB  = 25;
    localparam int RS1_LSB = 16;
    localparam int RS1_MSB = 20;
    localparam int RS2_LSB = 11;
    localparam int RS2_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int IMM_MSB = 15;

    typedef struct packed {
        logic [CMD_REG_W-1:0] rd;
        logic [CMD_REG_W-1:0] rs1;
        logic [CMD_REG_W-1:0] rs2;
        logic [CMD_IMM_W-1:0] imm;
        logic [CMD_OP_W-1:0]  operation;
        logic                 load;
        logic                 write_enable;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cmd_decode_queue_if.sv
// cmd_decode_queue_if: host write side, issue side and status of the
// command decode queue.
//   slave  : view used by cmd_decode_queue.
//   master : view used by the host / execution unit side.
// With CMD_PARITY_EN defined the bundle also carries write_parity and
// parity_err.
interface cmd_decode_queue_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int IMM_W  = 16,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [OP_W:0]       write_addr;
    logic [DATA_W-1:0]   write_data;
    logic                write;
    logic                write_ready;
    logic                flush;
    logic                issue_valid;
    logic                issue_ready;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [IMM_W-1:0]    imm;
    logic [OP_W-1:0]     operation;
    logic                load;
    logic                write_enable;
    logic [CNT_W-1:0]    count;
    logic                illegal_err;
    logic                overflow_err;
    logic                err_clear;
`ifdef CMD_PARITY_EN
    logic                write_parity;
    logic                parity_err;
`endif

    modport slave (
        input  write_addr, write_data, write, flush, issue_ready, err_clear,
`ifdef CMD_PARITY_EN
        input  write_parity,
        output parity_err,
`endif
        output write_ready, issue_valid, rd, rs1, rs2, imm, operation,
               load, write_enable, count, illegal_err, overflow_err
    );

    modport master (
        output write_addr, write_data, write, flush, issue_ready, err_clear,
`ifdef CMD_PARITY_EN
        output write_parity,
        input  parity_err,
`endif
        input  write_ready, issue_valid, rd, rs1, rs2, imm, operation,
               load, write_enable, count, illegal_err, overflow_err
    );

endinterface

// File: rtl/cmd_decode_queue_fifo.sv
// cmd_fifo: generic synchronous FIFO of packed words.
//   clk, rst  : clock, asynchronous active-high reset (control only).
//   push_i    : write data_i (ignored when full).
//   pop_i     : retire the head (ignored when empty).
//   flush_i   : empty the FIFO on the next edge; overrides push/pop.
//   data_o    : head word, read straight from storage.
//   count_o   : occupancy; full_o / empty_o derived from it.
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cmd_decode_queue.sv
// cmd_decode_queue: decodes host command writes (opcode on write_addr,
// packed fields on write_data), queues the decoded commands and issues
// them to the execution unit over a valid/ready handshake.
//   clk, rst : clock, asynchronous active-high reset.
//   bus      : cmd_decode_queue_if.slave - write side (write_addr,
//              write_data, write, write_ready), issue side (issue_valid,
//              issue_ready, rd, rs1, rs2, imm, operation, load,
//              write_enable), count, flush, sticky error flags and
//              err_clear.
// Build macro CMD_PARITY_EN adds an odd-parity check on
// {write_data, write_parity} with a sticky parity_err flag.
// Field widths REG_W/IMM_W/OP_W must match the widths of cmd_t.
module cmd_decode_queue
    import cmd_decode_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_W    = CMD_REG_W,
    parameter int IMM_W    = CMD_IMM_W,
    parameter int OP_W     = CMD_OP_W,
    parameter int DEPTH    = 4,
    parameter int LOAD_OP  = CMD_LOAD_OP,
    parameter int STORE_OP = CMD_STORE_OP
) (
    input  logic             clk,
    input  logic             rst,
    cmd_decode_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    cmd_t             cmd_in;
    cmd_t             cmd_head;
    logic [CNT_W-1:0] count;
    logic             full, empty;
    logic             illegal_op, parity_bad;
    logic             push, pop, issue_valid;
    logic             illegal_set, overflow_set;
    logic             illegal_err_q, illegal_err_d;
    logic             overflow_err_q, overflow_err_d;

`ifdef CMD_PARITY_EN
    logic             parity_set;
    logic             parity_err_q, parity_err_d;
    // Odd parity: the XOR over data and parity bit must be 1.
    assign parity_bad = ~^{bus.write_data, bus.write_parity};
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        cmd_in              = '0;
        cmd_in.rd           = bus.write_data[RD_MSB:RD_LSB];
        cmd_in.rs1          = bus.write_data[RS1_MSB:RS1_LSB];
        cmd_in.rs2          = bus.write_data[RS2_MSB:RS2_LSB];
        cmd_in.imm          = bus.write_data[IMM_MSB:IMM_LSB];
        cmd_in.operation    = bus.write_addr[OP_W-1:0];
        cmd_in.load         = (bus.write_addr[OP_W-1:0] == OP_W'(LOAD_OP));
        cmd_in.write_enable = (bus.write_addr[OP_W-1:0] != OP_W'(STORE_OP));
    end

    assign illegal_op = bus.write_addr[OP_W];
    assign push = bus.write && !full && !illegal_op && !parity_bad && !bus.flush;
    assign issue_valid = !empty;
    assign pop = issue_valid && bus.issue_ready && !bus.flush;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.flush),
        .data_i  (cmd_in),
        .data_o  (cmd_head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // A flushed write leaves every flag untouched.
    assign illegal_set  = bus.write && !bus.flush && illegal_op;
    assign overflow_set = bus.write && !bus.flush && full;

    // Set has priority over clear in the same cycle.
    assign illegal_err_d  = illegal_set  ? 1'b1 : (bus.err_clear ? 1'b0 : illegal_err_q);
    assign overflow_err_d = overflow_set ? 1'b1 : (bus.err_clear ? 1'b0 : overflow_err_q);

`ifdef CMD_PARITY_EN
    assign parity_set   = bus.write && !bus.flush && parity_bad;
    assign parity_err_d = parity_set ? 1'b1 : (bus.err_clear ? 1'b0 : parity_err_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_err_q  <= 1'b0;
            overflow_err_q <= 1'b0;
`ifdef CMD_PARITY_EN
            parity_err_q   <= 1'b0;
`endif
        end else begin
            illegal_err_q  <= illegal_err_d;
            overflow_err_q <= overflow_err_d;
`ifdef CMD_PARITY_EN
            parity_err_q   <= parity_err_d;
`endif
        end
    end

    // Head fields are forced to zero while nothing is valid.
    assign bus.issue_valid  = issue_valid;
    assign bus.rd           = issue_valid ? cmd_head.rd           : '0;
    assign bus.rs1          = issue_valid ? cmd_head.rs1          : '0;
    assign bus.rs2          = issue_valid ? cmd_head.rs2          : '0;
    assign bus.imm          = issue_valid ? cmd_head.imm          : '0;
    assign bus.operation    = issue_valid ? cmd_head.operation    : '0;
    assign bus.load         = issue_valid && cmd_head.load;
    assign bus.write_enable = issue_valid && cmd_head.write_enable;
    assign bus.write_ready  = !full;
    assign bus.count        = count;
    assign bus.illegal_err  = illegal_err_q;
    assign bus.overflow_err = overflow_err_q;
`ifdef CMD_PARITY_EN
    assign bus.parity_err   = parity_err_q;
`endif

endmodule

// File: doc/cmd_decode_queue.md
Name: cmd_decode_queue

Overview:
- Parametrised successor to the single-cycle command write decoder.
- Accepts host command writes as (write_addr = opcode, write_data = packed fields) and decodes them into rd/rs1/rs2/imm/operation/load/write_enable.
- Buffers decoded commands in a DEPTH-entry queue and issues them to the execution unit over a valid/ready handshake.
- Adds backpressure, illegal-opcode detection, overflow detection and flush.

Parameters:
- DATA_W, 32, command word width.
- REG_W, 5, register index width.
- IMM_W, 16, immediate width.
- OP_W, 4, operation width; legal opcodes 0..2**OP_W-1.
- DEPTH, 4, queue entries; power of two, >= 2.
- LOAD_OP, 12, opcode that asserts load.
- STORE_OP, 13, opcode that deasserts write_enable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- write_addr  in  OP_W+1  command opcode; MSB set = illegal.
- write_data  in  DATA_W  packed fields.
- write  in  1  command write strobe.
- write_ready  out  1  queue can accept; equals !full.
- flush  in  1  synchronous queue clear.
- issue_valid  out  1  head entry valid.
- issue_ready  in  1  consumer accepts head.
- rd, rs1, rs2  out  REG_W each  decoded register indices.
- imm  out  IMM_W  decoded immediate.
- operation  out  OP_W  decoded opcode.
- load  out  1  operation == LOAD_OP.
- write_enable  out  1  operation != STORE_OP.
- count  out  clog2(DEPTH)+1  occupancy.
- illegal_err  out  1  sticky illegal-opcode flag.
- overflow_err  out  1  sticky write-while-full flag.
- err_clear  in  1  clears the sticky flags.

Behaviour:
- Field map: rd = write_data[25:21], rs1 = [20:16], rs2 = [15:11], imm = [15:0], operation = write_addr[OP_W-1:0]. Unused bits are ignored.
- Push condition: write && !full && !write_addr[OP_W] && !flush. Decode happens at push; the entry stores all decoded fields.
- Pop condition: issue_valid && issue_ready && !flush.
- Latency: a push into an empty queue shows issue_valid=1 with its fields on the next cycle. No combinational path from write to the issue outputs.
- Issue outputs reflect the head entry combinationally from queue storage. They hold stable while issue_valid && !issue_ready. They are don't-care when issue_valid=0 but are driven to 0 then.
- Simultaneous push and pop with 0 < count <= DEPTH-1: count is unchanged and pointers advance.
- Push is refused when full, even if a pop occurs the same cycle.
- Pointers wrap modulo DEPTH. full = (count == DEPTH); empty = (count == 0).
- write && full: command dropped, overflow_err <= 1.
- write && write_addr[OP_W]: command dropped, illegal_err <= 1. If also full, both flags set.
- err_clear: flags <= 0. A same-cycle set wins over the clear.
- flush: pointers and count <= 0 next cycle. A same-cycle write is dropped with no flags set. Sticky flags are unaffected.
- Reset (async, any time, including mid-handshake): count=0, pointers=0, issue_valid=0, all field outputs 0, load=0, write_enable=0, illegal_err=0, overflow_err=0, write_ready=1. Queue storage is not reset.

Optional Feature:
- Macro CMD_PARITY_EN.
- Defined: adds input write_parity (1) and output parity_err (1, sticky, reset 0, cleared by err_clear). The command must satisfy odd parity over {write_data, write_parity}. On mismatch the command is dropped and parity_err <= 1. The parity check is evaluated alongside the illegal and full checks.
- Undefined: neither port exists and no check is performed.

Decomposition:
- Package cmd_decode_pkg holds:
  - field LSB/MSB localparams;
  - LOAD_OP and STORE_OP defaults;
  - a typedef cmd_t packing {rd, rs1, rs2, imm, operation, load, write_enable}.
- One sub-module, cmd_fifo: generic synchronous FIFO of cmd_t with push/pop/flush/count.
- Decode and error logic stay in cmd_decode_queue.

Test Plan:
- Reset then single LOAD: write_addr=12, write_data={11'd8,5'd13,16'd1234}, issue_ready=1.
  - Next cycle: issue_valid=1, rd=8, rs1=13, imm=1234, operation=12, load=1, write_enable=1.
  - Following cycle: count=0.
- R-type: write_addr=3, write_data={11'd0,5'd3,5'd4,11'd0}.
  - Issued: rs1=3, rs2=4, rd=0, operation=3, load=0, write_enable=1.
- Fill/backpressure: issue_ready=0, five writes with opcodes 1..5 (DEPTH=4).
  - After the 4th write: write_ready=0, count=4.
  - 5th write: dropped, overflow_err=1.
  - Then issue_ready=1: operations 1,2,3,4 issue in order, and nothing further.
- Illegal and store: write_addr=5'h13 -> count unchanged, illegal_err=1. err_clear -> 0. write_addr=13 -> issued with write_enable=0, load=0.
- Simultaneous push/pop at count=2 -> count stays 2 and order is preserved. flush with write asserted -> count=0 next cycle, no flag set.
- Async reset asserted mid-cycle while issue_valid=1 -> issue_valid=0 and count=0 immediately, without waiting for a clock edge.
- With CMD_PARITY_EN: write_data=32'h1, write_parity=1 -> dropped, parity_err=1. write_parity=0 -> accepted.
